// File: rtl/collatz_pkg.sv
// Shared types and defaults for the Collatz sequence generator.
// Holds the FSM state encoding and the default data width.
package collatz_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_step.sv
// One Collatz step: halve an even value, or form 3x+1 for an odd value.
// Purely combinational, no latency; no flow control.
// Flags x==1 and a 3x+1 result that does not fit the signed WIDTH range.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] next,
    output logic                    is_one,
    output logic                    ovf
);

    localparam logic signed [WIDTH+1:0] MAX_POS = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+1:0] ONE_EXT = {{(WIDTH+1){1'b0}}, 1'b1};
    localparam logic        [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic signed [WIDTH+1:0] x_ext;
    logic signed [WIDTH+1:0] tripled;

    always_comb begin
        x_ext   = {{2{x[WIDTH-1]}}, x};
        // Two guard bits keep 3x+1 exact so the range test is a plain compare.
        tripled = x_ext + (x_ext <<< 1) + ONE_EXT;
        is_one  = (x == ONE);
        next    = x >>> 1;
        ovf     = 1'b0;
        if (x[0]) begin
            next = tripled[WIDTH-1:0];
            ovf  = !is_one && (tripled > MAX_POS);
        end
    end

endmodule

// File: rtl/collatz_gen.sv
// Collatz sequence producer: latches n on _start and emits n, next(n), ..., 1.
// Latency: first element one cycle after the accepting edge, then one per cycle.
// No backpressure; _start is ignored while a sequence is running.
module collatz_gen
    import collatz_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    _clock,
    input  logic                    _reset,
    input  logic                    _start,
    input  logic signed [WIDTH-1:0] n,
    output logic signed [WIDTH-1:0] _out0,
    output logic                    _valid,
    output logic                    _done,
    output logic                    _overflow
);

    state_t                  state;
    logic signed [WIDTH-1:0] cur;
    logic                    valid_r;
    logic                    done_r;
    logic                    ovf_r;

    logic signed [WIDTH-1:0] step_next;
    logic                    step_is_one;
    logic                    step_ovf;

    collatz_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .x      (cur),
        .next   (step_next),
        .is_one (step_is_one),
        .ovf    (step_ovf)
    );

    always_ff @(posedge _clock) begin
        if (_reset) begin
            state   <= IDLE;
            cur     <= '0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (_start) begin
                        ovf_r <= 1'b0;
                        if (n[WIDTH-1] || (n == '0)) begin
                            cur     <= '0;
                            valid_r <= 1'b0;
                            done_r  <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cur     <= n;
                            valid_r <= 1'b1;
                            done_r  <= 1'b0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (step_is_one) begin
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end else if (step_ovf) begin
                        // Keep the last representable element on _out0 for inspection.
                        valid_r <= 1'b0;
                        done_r  <= 1'b1;
                        ovf_r   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cur     <= step_next;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // The final element 1 is flagged done in the same cycle it is presented.
    assign _out0     = cur;
    assign _valid    = valid_r;
    assign _done     = done_r | (valid_r && step_is_one);
    assign _overflow = ovf_r;

endmodule

// File: tb/tb_collatz_gen.sv
// Bench for collatz_gen: directed scenarios plus random seeds against an arithmetic sequence model.
module tb_collatz_gen;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [31:0] n_in;
    logic signed [31:0] out0;
    logic               valid;
    logic               done;
    logic               ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] o;
        logic        d;
        logic        f;
    } exp_t;

    collatz_gen #(.WIDTH(32)) dut (
        ._clock    (clk),
        ._reset    (rst),
        ._start    (start),
        .n         (n_in),
        ._out0     (out0),
        ._valid    (valid),
        ._done     (done),
        ._overflow (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected per-cycle outputs following an accepted start with seed s.
    function automatic void model(input longint s, output exp_t q[$], output int nvalid);
        longint x;
        exp_t   e;
        q = {};
        nvalid = 0;
        if (s <= 0) begin
            e = '{1'b0, 32'd0, 1'b1, 1'b0};
            q.push_back(e);
            return;
        end
        x = s;
        for (int k = 0; k < 5000; k++) begin
            e = '{1'b1, x[31:0], (x == 1), 1'b0};
            q.push_back(e);
            nvalid++;
            if (x == 1) begin
                e = '{1'b0, 32'd1, 1'b1, 1'b0};
                q.push_back(e);
                return;
            end
            if (x % 2 == 0) begin
                x = x / 2;
            end else if (3 * x + 1 > 64'sd2147483647) begin
                e = '{1'b0, x[31:0], 1'b1, 1'b1};
                q.push_back(e);
                return;
            end else begin
                x = 3 * x + 1;
            end
        end
    endfunction

    // Called at a negedge; returns at a negedge. pulse_at / reset_at are 1-based valid-cycle indices (0 = none).
    task automatic run(input string name, input int seed, input int pulse_at, input int pulse_n,
                       input int reset_at, input int want_valid);
        exp_t q[$];
        int   nvalid;
        int   seen;
        model(longint'(seed), q, nvalid);
        seen  = 0;
        start = 1'b1;
        n_in  = seed;
        foreach (q[i]) begin
            @(negedge clk);
            start = 1'b0;
            check({name, " valid"},    64'(valid), 64'(q[i].v));
            check({name, " out0"},     64'(out0),  64'(q[i].o));
            check({name, " done"},     64'(done),  64'(q[i].d));
            check({name, " overflow"}, 64'(ovf),   64'(q[i].f));
            if (valid) seen++;
            if (pulse_at != 0 && i == pulse_at - 1) begin
                start = 1'b1;
                n_in  = pulse_n;
            end
            if (reset_at != 0 && i == reset_at - 1) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({name, " rst out0"},     64'(out0),  64'd0);
                check({name, " rst valid"},    64'(valid), 64'd0);
                check({name, " rst done"},     64'(done),  64'd0);
                check({name, " rst overflow"}, 64'(ovf),   64'd0);
                @(negedge clk);
                check({name, " idle done"},    64'(done),  64'd0);
                check({name, " idle valid"},   64'(valid), 64'd0);
                return;
            end
        end
        check({name, " valid count"}, 64'(seen), 64'(nvalid));
        if (want_valid >= 0) check({name, " spec length"}, 64'(seen), 64'(want_valid));
        @(negedge clk);
        check({name, " hold valid"}, 64'(valid), 64'd0);
        check({name, " hold done"},  64'(done),  64'd1);
        check({name, " hold out0"},  64'(out0),  64'(q[q.size()-1].o));
        check({name, " hold ovf"},   64'(ovf),   64'(q[q.size()-1].f));
    endtask

    initial begin
        int s;
        rst   = 1'b1;
        start = 1'b1;
        n_in  = 32'sd9;
        @(negedge clk);
        @(negedge clk);
        check("reset out0",     64'(out0),  64'd0);
        check("reset valid",    64'(valid), 64'd0);
        check("reset done",     64'(done),  64'd0);
        check("reset overflow", 64'(ovf),   64'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle done", 64'(done), 64'd0);

        run("n15",  15, 0, 0, 0, 18);
        run("n1",   1, 0, 0, 0, 1);
        run("n0",   0, 0, 0, 0, 0);
        run("nneg", -5, 0, 0, 0, 0);
        run("nmax", 32'h7fffffff, 0, 0, 0, 1);
        run("n27",  27, 5, 3, 0, 112);
        run("n3",   3, 0, 0, 0, 8);
        run("n15r", 15, 0, 0, 4, -1);
        run("n6",   6, 0, 0, 0, 9);

        for (int k = 0; k < 24; k++) begin
            if (k % 3 == 2) s = int'($urandom);
            else s = int'($urandom_range(1, 200000));
            run("rand", s, 0, 0, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collatz_gen.md
Name: collatz_gen

Overview:
- Synthesizable generator core driving the `_start` / `_valid` / `_out0` / `_done` output protocol used by the codebase's generator testbenches.
- This block is the producer side of that protocol.
- On `_start` it latches signed input `n` and then emits the Collatz sequence of `n`, one value per clock: n, next(n), …, 1.
- It is the hand-written golden producer against which generated generator modules and their benches are cross-checked.

Parameters:
- WIDTH, 32, data width of `n` and `_out0` (two's-complement signed).

Ports:
- `_clock`  in  1  single clock; all logic on posedge.
- `_reset`  in  1  synchronous, active-high reset.
- `_start`  in  1  start request; sampled on posedge.
- `n`  in  WIDTH  signed seed; sampled only on the posedge where `_start` is accepted.
- `_out0`  out  WIDTH  signed current sequence value.
- `_valid`  out  1  `_out0` holds a sequence element this cycle.
- `_done`  out  1  sequence finished; held high until the next accepted `_start`.
- `_overflow`  out  1  sequence aborted because 3x+1 exceeded the signed WIDTH range.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (sync, `_reset`=1 at posedge), from any state including mid-RUN:
  - state←IDLE; `_out0`=0, `_valid`=0, `_done`=0, `_overflow`=0.
  - `_reset` has priority over `_start` in the same cycle.
- IDLE or DONE, `_start`=1 at posedge k:
  - Latch `n`; `_done`←0, `_overflow`←0.
  - If n≤0: at k+1, `_valid`=0, `_done`=1, `_out0`=0; go to DONE (no elements emitted).
  - Otherwise: at k+1, `_out0`=n, `_valid`=1; go to RUN.
- RUN, each posedge with current value x:
  - x==1: element already presented with `_done`=1 in the same cycle (see termination). Next cycle: `_valid`=0, `_done`=1, `_out0` holds 1; state DONE.
  - x even: `_out0`←x>>1 (arithmetic), `_valid`=1.
  - x odd, x≠1:
    - Compute 3x+1 in WIDTH+2 bits.
    - If result > 2^(WIDTH-1)−1: `_valid`←0, `_done`←1, `_overflow`←1, `_out0` holds x; state DONE.
    - Else `_out0`←3x+1, `_valid`=1.
- Termination:
  - `_done` is combinationally asserted in the same cycle that `_out0`==1 is presented with `_valid`=1.
  - The final element is therefore observed with `_valid`=1 and `_done`=1 together.
  - The following cycle keeps `_done`=1 with `_valid`=0.
- `_start` while in RUN: ignored; the sequence continues undisturbed.
- DONE: outputs hold (`_done`=1, `_valid`=0) until `_start` or `_reset`.
- IDLE: `_done`=0, `_valid`=0.
- Latency: first element 1 cycle after the accepting edge; throughput 1 element/cycle; no backpressure.
- `_out0` is always registered. `_done` is registered, except for the x==1 combinational term.

Decomposition:
- Package `collatz_pkg`: state enum (IDLE, RUN, DONE), default WIDTH constant.
- Sub-module `collatz_step`: combinational; input x (WIDTH); outputs next (WIDTH), is_one, ovf. Implements the even/odd rule and the WIDTH+2 overflow check.
- The FSM and registers stay in `collatz_gen`.

Test Plan:
- n=15, `_start` pulse:
  - Exactly 18 `_valid` cycles: 15,46,23,70,35,106,53,160,80,40,20,10,5,16,8,4,2,1.
  - `_done`=1 first on the cycle showing 1 with `_valid`=1; `_overflow`=0.
- n=1:
  - Cycle after start: `_out0`=1, `_valid`=1, `_done`=1.
  - Next cycle: `_valid`=0, `_done`=1.
- n=0, then n=−5:
  - Each: cycle after start shows `_valid`=0, `_done`=1, `_out0`=0, `_overflow`=0.
- n=2^31−1 (WIDTH=32):
  - Cycle 1: `_out0`=2147483647, `_valid`=1.
  - Cycle 2: `_valid`=0, `_done`=1, `_overflow`=1.
- n=27 started, `_start` re-pulsed with n=3 at the 5th valid cycle:
  - Pulse ignored; full 112-element run of 27 completes, ending at 1.
  - `_start` with n=3 in DONE then yields 3,10,5,16,8,4,2,1.
- n=15 started, `_reset`=1 at the 4th valid cycle:
  - Next cycle all outputs 0, state IDLE.
  - A following `_start` with n=6 yields 6,3,10,5,16,8,4,2,1.
